// File: rtl/we_word_packer.sv
// we_word_packer: packs a valid/ready byte stream little-endian into
// WORD_W-bit words and emits each one as a single-cycle wn strobe.
// A flush pushes out a partial word with its unfilled upper bytes zeroed.
module we_word_packer #(
    parameter  int BYTES  = 8,
    parameter  int BYTE_W = 8,
    localparam int WORD_W = BYTES * BYTE_W,
    localparam int CNT_W  = $clog2(BYTES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              flush,
    output logic              wn,
    output logic [WORD_W-1:0] word_out,
    output logic              partial,
    output logic [CNT_W-1:0]  byte_cnt
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  buf_q,   buf_d;
    logic [WORD_W-1:0]  word_q,  word_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               wn_q,    wn_d;
    logic               partial_q, partial_d;
    logic               accept;

    // Ready depends only on state and reset, so there is no path from byte_valid.
    assign byte_ready = !reset && (state_q == S_FILL);
    assign accept     = byte_valid && byte_ready;

    // Next-state logic: place accepted bytes, decide when a word is emitted.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        wn_d      = 1'b0;
        partial_d = 1'b0;

        unique case (state_q)
            S_FILL: begin
                // The k-th accepted byte lands in lane k.
                for (int k = 0; k < BYTES; k++) begin
                    if (accept && (cnt_q == CNT_W'(k))) begin
                        buf_d[k*BYTE_W +: BYTE_W] = byte_in;
                    end
                end
                cnt_d = cnt_q + CNT_W'(accept);

                if (cnt_d == CNT_W'(BYTES)) begin
                    // Full word, even if flush arrived with the completing byte.
                    state_d = S_EMIT;
                    wn_d    = 1'b1;
                    word_d  = buf_d;
                end else if (flush && (cnt_d != '0)) begin
                    // Unfilled lanes are already zero because the buffer clears on emit.
                    state_d   = S_EMIT;
                    wn_d      = 1'b1;
                    partial_d = 1'b1;
                    word_d    = buf_d;
                end
            end

            S_EMIT: begin
                // One-cycle emit: stall input, ignore flush, restart accumulation.
                state_d = S_FILL;
                buf_d   = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_FILL;
                buf_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs, synchronously reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= S_FILL;
            buf_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            wn_q      <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            wn_q      <= wn_d;
            partial_q <= partial_d;
        end
    end

    assign wn       = wn_q;
    assign word_out = word_q;
    assign partial  = partial_q;
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_we_word_packer.sv
// Directed self-checking bench for we_word_packer at default parameters.
module tb_we_word_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic        wn;
    logic [63:0] word_out;
    logic        partial;
    logic [3:0]  byte_cnt;

    int checks;
    int errors;
    int wn_count;
    logic prev_wn;
    logic double_wn;
    logic stray_partial;

    we_word_packer dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .flush      (flush),
        .wn         (wn),
        .word_out   (word_out),
        .partial    (partial),
        .byte_cnt   (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge: count strobes, flag back-to-back wn and partial without wn.
    initial begin
        prev_wn = 1'b0; double_wn = 1'b0; stray_partial = 1'b0; wn_count = 0;
    end
    always @(negedge clk) begin
        if (wn) wn_count++;
        if (wn && prev_wn) double_wn = 1'b1;
        if (!wn && partial) stray_partial = 1'b1;
        prev_wn = wn;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte (optionally with flush) and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input logic fl);
        byte_in    = b;
        byte_valid = 1'b1;
        flush      = fl;
        for (int i = 0; i < 8 && !byte_ready; i++) tick();
        if (!byte_ready) check("ready_timeout", 64'd0, 64'd1);
        tick();
        byte_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int idx;
        int cycles;
        int low_cycles;
        logic [63:0] words [2];
        int nwords;
        logic [63:0] held;

        checks = 0; errors = 0;
        reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0;
        tick();
        check("rst_ready", byte_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_wn", wn, 0);
        check("rst_word", word_out, 64'h0);
        check("rst_partial", partial, 0);
        check("rst_cnt", byte_cnt, 0);
        check("rst_ready_after", byte_ready, 1);

        // Full word 0x01..0x08.
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b0);
        check("full_wn", wn, 1);
        check("full_word", word_out, 64'h0807060504030201);
        check("full_partial", partial, 0);
        check("full_cnt", byte_cnt, 8);
        check("full_ready_emit", byte_ready, 0);
        tick();
        check("full_wn_drop", wn, 0);
        check("full_cnt_clear", byte_cnt, 0);
        check("full_ready_back", byte_ready, 1);
        check("full_word_held", word_out, 64'h0807060504030201);

        // Flush partial with no byte.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        check("fp_cnt", byte_cnt, 3);
        do_flush();
        check("fp_wn", wn, 1);
        check("fp_word", word_out, 64'h0000000000CCBBAA);
        check("fp_partial", partial, 1);
        tick();
        check("fp_partial_clear", partial, 0);

        // Flush together with the third byte.
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        check("fb_wn", wn, 1);
        check("fb_word", word_out, 64'h0000000000332211);
        check("fb_partial", partial, 1);
        tick();

        // Flush together with the completing eighth byte: one full word.
        base = wn_count;
        for (int i = 0; i < 7; i++) send_byte(8'h40 + 8'(i), 1'b0);
        send_byte(8'h47, 1'b1);
        check("f8_wn", wn, 1);
        check("f8_word", word_out, 64'h4746454443424140);
        check("f8_partial", partial, 0);
        tick();
        tick();
        check("f8_single_wn", wn_count, base + 1);
        check("f8_cnt", byte_cnt, 0);

        // Empty flush for three cycles is ignored.
        base = wn_count;
        held = word_out;
        flush = 1'b1;
        tick(); tick(); tick();
        flush = 1'b0;
        tick();
        check("ef_wn_count", wn_count, base);
        check("ef_word", word_out, held);
        check("ef_cnt", byte_cnt, 0);

        // Back-to-back 0x00..0x0F with valid held high.
        idx = 0; cycles = 0; low_cycles = 0; nwords = 0;
        byte_valid = 1'b1;
        while (idx < 16 && cycles < 40) begin
            logic acc;
            byte_in = 8'(idx);
            acc = byte_ready;
            if (!acc) low_cycles++;
            tick();
            cycles++;
            if (acc) idx++;
            if (wn && nwords < 2) begin
                words[nwords] = word_out;
                nwords++;
            end
        end
        byte_valid = 1'b0;
        check("b2b_accepted", idx, 16);
        check("b2b_cycles", cycles, 17);
        check("b2b_low", low_cycles, 1);
        check("b2b_nwords", nwords, 2);
        check("b2b_word0", words[0], 64'h0706050403020100);
        check("b2b_word1", words[1], 64'h0F0E0D0C0B0A0908);
        check("b2b_last_ready", byte_ready, 0);
        tick();

        // Reset mid-fill discards accumulated bytes.
        for (int i = 0; i < 5; i++) send_byte(8'h90 + 8'(i), 1'b0);
        check("rm_cnt_before", byte_cnt, 5);
        base = wn_count;
        reset = 1'b1;
        #1;
        check("rm_ready_in_reset", byte_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rm_cnt", byte_cnt, 0);
        check("rm_wn", wn, 0);
        for (int i = 0; i < 8; i++) send_byte(8'hF0 + 8'(i), 1'b0);
        check("rm_word", word_out, 64'hF7F6F5F4F3F2F1F0);
        check("rm_partial", partial, 0);
        tick();
        tick();
        check("rm_wn_count", wn_count, base + 1);

        check("never_double_wn", double_wn, 0);
        check("never_stray_partial", stray_partial, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
